// File: rtl/lsb_events_pkg.sv
// rtl/lsb_events_pkg.sv - register map and event bit layout shared by the LED/switch/button reader
package lsb_events_pkg;

    localparam logic [1:0] ADR_STATE = 2'd0;
    localparam logic [1:0] ADR_EVT   = 2'd1;
    localparam logic [1:0] ADR_MASK  = 2'd2;

    localparam int EVT_PRESS = 0;
    localparam int EVT_REL   = 8;
    localparam int EVT_SWI   = 16;

    // Bits of the events/mask registers that actually exist for a given input count
    function automatic logic [31:0] evt_impl(input int nbtn, input int nswi);
        logic [31:0] m;
        m = '0;
        for (int i = 0; i < nbtn; i++) begin
            m[EVT_PRESS + i] = 1'b1;
            m[EVT_REL + i]   = 1'b1;
        end
        for (int j = 0; j < nswi; j++) begin
            m[EVT_SWI + j] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/lsb_dbnc_sync.sv
// rtl/lsb_dbnc_sync.sv - two-flop synchronizer plus stable-count debouncer for one raw pin
module lsb_dbnc_sync #(
    parameter int DBNC_CNT = 50000,
    parameter int CW       = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic state
);

    localparam logic [CW-1:0] CNT_LAST = CW'(DBNC_CNT - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
            state <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            // Any sample that agrees with the current state discards progress
            if (sync2 == state) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                state <= sync2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/lsb_events.sv
// rtl/lsb_events.sv - debounced button/switch reader with sticky W1C events and maskable irq
module lsb_events
    import lsb_events_pkg::*;
#(
    parameter int NBTN     = 5,
    parameter int NSWI     = 8,
    parameter int DBNC_CNT = 50000,
    parameter int CW       = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NBTN-1:0] hwbtn,
    input  logic [NSWI-1:0] hwswi,
    input  logic [1:0]      adr,
    input  logic            rd,
    input  logic            wr,
    input  logic [31:0]     wdata,
    output logic [31:0]     rdata,
    output logic            irq
);

    localparam int          NIN      = NBTN + NSWI;
    localparam logic [31:0] EVT_IMPL = evt_impl(NBTN, NSWI);

    logic [NIN-1:0] raw;
    logic [NIN-1:0] db;
    logic [NIN-1:0] db_prev;
    logic [31:0]    state_word;
    logic [31:0]    set_vec;
    logic [31:0]    events;
    logic [31:0]    mask;

    assign raw = {hwswi, hwbtn};

    for (genvar g = 0; g < NIN; g++) begin : gen_dbnc
        lsb_dbnc_sync #(
            .DBNC_CNT(DBNC_CNT),
            .CW      (CW)
        ) u_dbnc (
            .clk  (clk),
            .rst  (rst),
            .raw  (raw[g]),
            .state(db[g])
        );
    end

    always_comb begin
        state_word = '0;
        set_vec    = '0;
        for (int i = 0; i < NBTN; i++) begin
            state_word[i]             = db[i];
            set_vec[EVT_PRESS + i]    = db[i] & ~db_prev[i];
            set_vec[EVT_REL + i]      = ~db[i] & db_prev[i];
        end
        for (int j = 0; j < NSWI; j++) begin
            state_word[8 + j]         = db[NBTN + j];
            set_vec[EVT_SWI + j]      = db[NBTN + j] ^ db_prev[NBTN + j];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            db_prev <= '0;
            events  <= '0;
            mask    <= '0;
            rdata   <= '0;
            irq     <= 1'b0;
        end else begin
            db_prev <= db;
            // A new edge in the same cycle as its clear keeps the bit set
            if (wr && adr == ADR_EVT) begin
                events <= (events & ~wdata) | set_vec;
            end else begin
                events <= events | set_vec;
            end
            if (wr && adr == ADR_MASK) begin
                mask <= wdata & EVT_IMPL;
            end
            if (rd) begin
                case (adr)
                    ADR_STATE: rdata <= state_word;
                    ADR_EVT:   rdata <= events;
                    ADR_MASK:  rdata <= mask;
                    default:   rdata <= '0;
                endcase
            end
            irq <= |(events & mask);
        end
    end

endmodule

// File: tb/tb_lsb_events.sv
// tb/tb_lsb_events.sv - self-checking bench for lsb_events with short debounce count
module tb_lsb_events;

    logic        clk;
    logic        rst;
    logic [4:0]  hwbtn;
    logic [7:0]  hwswi;
    logic [1:0]  adr;
    logic        rd;
    logic        wr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q[$];

    typedef struct {
        logic        rd;
        logic        wr;
        logic [1:0]  adr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[14];

    lsb_events #(
        .NBTN    (5),
        .NSWI    (8),
        .DBNC_CNT(4),
        .CW      (4)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .hwbtn(hwbtn),
        .hwswi(hwswi),
        .adr  (adr),
        .rd   (rd),
        .wr   (wr),
        .wdata(wdata),
        .rdata(rdata),
        .irq  (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // All tasks start and end 1 time unit after a rising edge
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus(input string name, input logic r, input logic w, input logic [1:0] a,
                       input logic [31:0] wd, input logic [31:0] exp);
        rd    = r;
        wr    = w;
        adr   = a;
        wdata = wd;
        if (r) exp_q.push_back(exp);
        tick(1);
        rd = 1'b0;
        wr = 1'b0;
        if (r) begin
            if (exp_q.size() == 0) begin
                chk({name, "_queue"}, 32'd1, 32'd0);
            end else begin
                chk(name, rdata, exp_q.pop_front());
            end
        end
    endtask

    task automatic rdreg(input string name, input logic [1:0] a, input logic [31:0] exp);
        bus(name, 1'b1, 1'b0, a, 32'h0, exp);
    endtask

    task automatic wrreg(input logic [1:0] a, input logic [31:0] wd);
        bus("wr", 1'b0, 1'b1, a, wd, 32'h0);
    endtask

    initial begin
        tbl[0]  = '{1'b1, 1'b0, 2'd0, 32'h0,        32'h0};
        tbl[1]  = '{1'b1, 1'b0, 2'd1, 32'h0,        32'h0};
        tbl[2]  = '{1'b1, 1'b0, 2'd2, 32'h0,        32'h0};
        tbl[3]  = '{1'b1, 1'b0, 2'd3, 32'h0,        32'h0};
        tbl[4]  = '{1'b0, 1'b1, 2'd2, 32'hFFFFFFFF, 32'h0};
        tbl[5]  = '{1'b1, 1'b0, 2'd2, 32'h0,        32'h00FF1F1F};
        tbl[6]  = '{1'b0, 1'b1, 2'd2, 32'h12345678, 32'h0};
        tbl[7]  = '{1'b1, 1'b0, 2'd2, 32'h0,        32'h00341618};
        tbl[8]  = '{1'b1, 1'b1, 2'd2, 32'h0,        32'h00341618};
        tbl[9]  = '{1'b1, 1'b0, 2'd2, 32'h0,        32'h0};
        tbl[10] = '{1'b0, 1'b1, 2'd0, 32'hFFFFFFFF, 32'h0};
        tbl[11] = '{1'b1, 1'b0, 2'd0, 32'h0,        32'h0};
        tbl[12] = '{1'b0, 1'b1, 2'd1, 32'hFFFFFFFF, 32'h0};
        tbl[13] = '{1'b1, 1'b0, 2'd1, 32'h0,        32'h0};

        rst = 1'b1; hwbtn = '0; hwswi = '0; adr = '0; rd = 1'b0; wr = 1'b0; wdata = '0;
        tick(3);
        rst = 1'b0;
        chk("reset_rdata", rdata, 32'h0);
        chk("reset_irq", {31'h0, irq}, 32'h0);

        for (int i = 0; i < 14; i++) begin
            bus($sformatf("tbl%0d", i), tbl[i].rd, tbl[i].wr, tbl[i].adr, tbl[i].wdata, tbl[i].exp);
        end

        // press btn2: state must flip exactly 6 cycles after the raw change
        hwbtn[2] = 1'b1;
        tick(5);
        rdreg("btn2_state_early", 2'd0, 32'h0);
        rdreg("btn2_state_on", 2'd0, 32'h00000004);
        rdreg("btn2_press_evt", 2'd1, 32'h00000004);
        chk("btn2_irq_masked", {31'h0, irq}, 32'h0);

        hwbtn[2] = 1'b0;
        tick(8);
        rdreg("btn2_release_evt", 2'd1, 32'h00000404);
        tick(2);
        chk("rdata_hold", rdata, 32'h00000404);
        rdreg("btn2_state_off", 2'd0, 32'h0);

        // glitch on swi5 shorter than the debounce window
        wrreg(2'd1, 32'hFFFFFFFF);
        hwswi[5] = 1'b1;
        tick(3);
        hwswi[5] = 1'b0;
        tick(8);
        rdreg("glitch_state", 2'd0, 32'h0);
        rdreg("glitch_evt", 2'd1, 32'h0);
        hwswi[5] = 1'b1;
        tick(10);
        rdreg("swi5_state", 2'd0, 32'h00002000);
        rdreg("swi5_evt", 2'd1, 32'h00200000);

        // interrupt on btn0 press
        wrreg(2'd1, 32'hFFFFFFFF);
        wrreg(2'd2, 32'h00000001);
        hwbtn[0] = 1'b1;
        tick(6);
        chk("irq_before_evt", {31'h0, irq}, 32'h0);
        tick(1);
        chk("irq_at_evt", {31'h0, irq}, 32'h0);
        rdreg("btn0_evt", 2'd1, 32'h00000001);
        chk("irq_rise", {31'h0, irq}, 32'h1);
        wrreg(2'd1, 32'h00000001);
        chk("irq_clear_lag", {31'h0, irq}, 32'h1);
        tick(1);
        chk("irq_cleared", {31'h0, irq}, 32'h0);

        // W1C in the same cycle as a fresh btn0 rise pulse
        hwbtn[0] = 1'b0;
        tick(8);
        chk("irq_release_masked", {31'h0, irq}, 32'h0);
        hwbtn[0] = 1'b1;
        tick(6);
        wrreg(2'd1, 32'h00000001);
        rdreg("collide_evt", 2'd1, 32'h00000101);
        chk("collide_irq", {31'h0, irq}, 32'h1);
        tick(1);
        chk("collide_irq_hold", {31'h0, irq}, 32'h1);

        // reset while btn1 debounce is mid-count
        hwbtn[0] = 1'b0;
        tick(8);
        wrreg(2'd1, 32'hFFFFFFFF);
        hwbtn[0] = 1'b1;
        hwswi[0] = 1'b1;
        tick(8);
        rdreg("pre_rst_evt", 2'd1, 32'h00010001);
        chk("pre_rst_irq", {31'h0, irq}, 32'h1);
        hwbtn[1] = 1'b1;
        tick(4);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_irq", {31'h0, irq}, 32'h0);
        rdreg("rst_state", 2'd0, 32'h0);
        rdreg("rst_evt", 2'd1, 32'h0);
        rdreg("rst_mask", 2'd2, 32'h0);
        tick(2);
        rdreg("rst_state_early", 2'd0, 32'h0);
        rdreg("rst_evt_early", 2'd1, 32'h0);
        rdreg("rst_evt_fresh", 2'd1, 32'h00210003);
        rdreg("rst_state_on", 2'd0, 32'h00002103);
        chk("rst_irq_masked", {31'h0, irq}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lsb_events.md
Name: lsb_events

Overview:
- Reader side of the board LED/switch/button block: samples the 5 buttons and 8 switches and debounces them.
- Detects press, release and toggle edges and keeps them as sticky event bits for the CPU.
- Raises a maskable interrupt when an enabled event is pending.
- Sits on the I/O bus next to the LED writer. The CPU polls or takes the interrupt, then clears events with write-1-to-clear.

Parameters:
- NBTN, 5, number of button inputs (1..8).
- NSWI, 8, number of switch inputs (1..8).
- DBNC_CNT, 50000, number of consecutive stable sampled cycles before a debounced state changes (>=2).
- CW, 16, debounce counter width; must satisfy 2**CW > DBNC_CNT.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- hwbtn  in  NBTN  raw button pins, asynchronous
- hwswi  in  NSWI  raw switch pins, asynchronous
- adr  in  2  register select: 0 state, 1 events, 2 irq mask
- rd  in  1  read strobe, 1 cycle
- wr  in  1  write strobe, 1 cycle
- wdata  in  32  write data
- rdata  out  32  read data, registered
- irq  out  1  level interrupt, registered

Behaviour:
- Reset: all sync flops, counters, debounced states, event bits, mask, rdata and irq are 0.
- Synchronizer: each raw input passes through 2 flops. The debouncer sees s = sync2.
- Debouncer, per input:
  - If s == state, the counter clears to 0.
  - Otherwise the counter increments. When it reaches DBNC_CNT-1, state <= s and the counter clears.
  - A single-cycle glitch resets progress.
  - Latency from a stable raw change to the state change is 2 + DBNC_CNT cycles.
- Edge detect: each debounced bit is compared with its previous-cycle value, giving 1-cycle rise/fall pulses.
- Register 0, state (read-only): bits [NBTN-1:0] hold the debounced buttons, bits [8+NSWI-1:8] hold the debounced switches, all other bits read 0.
- Register 1, events (sticky):
  - Bits [4:0]: button press (rise).
  - Bits [12:8]: button release (fall).
  - Bits [23:16]: switch toggle (rise or fall).
  - A write to adr 1 clears every bit whose wdata bit is 1.
  - If set and clear hit the same bit in the same cycle, set wins and the bit stays 1.
  - Unimplemented bits read 0.
- Register 2, mask: read/write with the same bit layout as events. Unimplemented bits are not stored and read 0.
- Bus timing:
  - rd asserted in cycle N gives rdata valid in cycle N+1.
  - rdata holds its value until the next rd.
  - Reading adr 3 returns 0.
  - rd and wr together: the read returns the pre-write value.
- irq <= |(events & mask), registered: one cycle after the event bit sets, and one cycle after the clear or mask write takes effect.
- Reset mid-debounce: the counter is discarded, and no event is generated by reset itself (the previous-state register is also reset to 0).
- Inputs held at 1 through reset: after reset the state rises once debounced, which produces a press/toggle event. This is intended.

Decomposition:
- Shared package holds:
  - register address constants: ADR_STATE=0, ADR_EVT=1, ADR_MASK=2.
  - bit-offset constants: EVT_PRESS=0, EVT_REL=8, EVT_SWI=16.
- One sub-module, lsb_dbnc_sync: 2-flop synchronizer plus debounce counter, parameterised by DBNC_CNT and CW, with ports clk, rst, raw, state.
- The top instantiates lsb_dbnc_sync NBTN+NSWI times in a generate loop.

Test Plan (DBNC_CNT=4 for simulation):
1. Reset: hold all raw inputs at 0, deassert rst, read adr 0, 1 and 2 -> each rdata = 0x00000000 and irq = 0.
2. Debounce and press/release:
   - Raise hwbtn[2] and keep it stable -> state bit 2 = 1 exactly 6 cycles after the raw change, and a read of adr 1 returns 0x00000004.
   - Drop hwbtn[2] and let it settle -> adr 1 returns 0x00000404.
3. Glitch rejection: pulse hwswi[5] high for 3 cycles, then low -> state and events stay 0. Hold it high for 10 cycles -> adr 0 = 0x00002000 and adr 1 = 0x00200000.
4. Interrupt and clear:
   - Write mask 0x00000001, then press btn0 -> irq rises 1 cycle after events bit 0 sets.
   - Write adr 1 with 0x00000001 -> irq is 0 two cycles later.
5. Set/clear collision: issue the W1C of bit 0 in the same cycle as a new btn0 rise pulse -> events bit 0 remains 1 and irq stays 1.
6. Reset mid-operation: assert rst while a debounce counter is at 2 with events = 0x00010001 -> after reset all registers read 0, and the held input produces a fresh event only after the full 2+DBNC_CNT cycles.
